// File: rtl/fetch_unit.sv
// fetch_unit: decoupled instruction fetch with credit-based issue, DEPTH-entry buffer and redirect flush
module fetch_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int INSTR_WIDTH = 32,
   parameter int DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
   parameter logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4)
) (
   input  logic                         clk,
   input  logic                         rst,
   output logic                         imem_req,
   output logic [ADDR_WIDTH-1:0]        imem_addr,
   input  logic [INSTR_WIDTH-1:0]       imem_rdata,
   input  logic                         redirect,
   input  logic [ADDR_WIDTH-1:0]        redirect_pc,
   output logic                         instr_valid,
   input  logic                         instr_ready,
   output logic [INSTR_WIDTH-1:0]       instr,
   output logic [ADDR_WIDTH-1:0]        instr_pc,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH-1);

   logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d, inflight_pc_q, inflight_pc_d;
   logic                   inflight_q, inflight_d;
   logic [INSTR_WIDTH-1:0] instr_mem_q [DEPTH];
   logic [INSTR_WIDTH-1:0] instr_mem_d [DEPTH];
   logic [ADDR_WIDTH-1:0]  pc_mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0]  pc_mem_d [DEPTH];
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]          count_q, count_d;
   logic [CW:0]            used;
   logic                   pop, push;

   always_comb begin
      pop = (count_q != '0) & instr_ready;
      push = inflight_q & ~redirect;
      // a slot freed by this cycle's pop is reusable immediately, sustaining one fetch per cycle
      used = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
      imem_req = ~rst & ~redirect & (used < (CW+1)'(DEPTH));
      fetch_pc_d = redirect ? redirect_pc : imem_req ? fetch_pc_q + PC_STEP : fetch_pc_q;
      inflight_d = imem_req;
      inflight_pc_d = imem_req ? fetch_pc_q : inflight_pc_q;
      rd_ptr_d = redirect ? '0 : !pop ? rd_ptr_q : rd_ptr_q == LAST ? '0 : rd_ptr_q + PW'(1);
      wr_ptr_d = redirect ? '0 : !push ? wr_ptr_q : wr_ptr_q == LAST ? '0 : wr_ptr_q + PW'(1);
      count_d = redirect ? '0 : count_q + CW'(push) - CW'(pop);
      instr_mem_d = instr_mem_q;
      pc_mem_d = pc_mem_q;
      if (push) begin
         instr_mem_d[wr_ptr_q] = imem_rdata;
         pc_mem_d[wr_ptr_q] = inflight_pc_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         inflight_q <= 1'b0;
         inflight_pc_q <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_mem_q[i] <= '0;
            pc_mem_q[i] <= '0;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         inflight_q <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q <= count_d;
         instr_mem_q <= instr_mem_d;
         pc_mem_q <= pc_mem_d;
      end
   end

   assign imem_addr = fetch_pc_q;
   assign instr_valid = count_q != '0;
   assign instr = instr_mem_q[rd_ptr_q];
   assign instr_pc = pc_mem_q[rd_ptr_q];
   assign count = count_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed timing checks plus random redirect/backpressure run against a PC-stream scoreboard
module tb_fetch_unit;
   localparam logic [31:0] K = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        rst, redirect, instr_ready;
   logic [31:0] redirect_pc, imem_addr, imem_rdata, instr, instr_pc;
   logic        imem_req, instr_valid;
   logic [2:0]  count;

   logic        w_req, w_valid;
   logic [31:0] w_addr, w_rdata, w_instr, w_pc;
   logic [2:0]  w_count;

   int n_checks = 0, n_pass = 0, w_pops = 0;
   logic [31:0] exp_q[$];
   logic [31:0] sb_e, w_exp;

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .count(count)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
      .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
      .redirect(1'b0), .redirect_pc(32'h0), .instr_valid(w_valid),
      .instr_ready(1'b1), .instr(w_instr), .instr_pc(w_pc), .count(w_count)
   );

   // synchronous-read memory whose content is a function of the address
   always @(posedge clk) begin
      imem_rdata <= imem_addr ^ K;
      w_rdata <= w_addr ^ K;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic restart(input logic [31:0] pc);
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(pc + 32'(i * 4));
   endtask

   // reference: after reset/redirect the delivered stream is pc, pc+4, ... with data pc^K
   always @(negedge clk or posedge rst) begin
      if (rst) restart(32'h0);
      else begin
         chk("valid_vs_count", instr_valid, count != 3'd0);
         chk("count_bound", count <= 3'd4, 1'b1);
         if (instr_valid && instr_ready) begin
            sb_e = exp_q.pop_front();
            exp_q.push_back(exp_q[$] + 32'd4);
            chk("sb_pc", instr_pc, sb_e);
            chk("sb_instr", instr, sb_e ^ K);
         end
         if (redirect) restart(redirect_pc);
      end
   end

   always @(negedge clk or posedge rst) begin
      if (rst) w_exp = 32'hFFFF_FFF8;
      else if (w_valid) begin
         chk("wrap_pc", w_pc, w_exp);
         chk("wrap_instr", w_instr, w_exp ^ K);
         w_exp += 32'd4;
         w_pops++;
      end
   end

   initial begin
      rst = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", instr_valid, 0);
      chk("rst_req", imem_req, 0);
      chk("rst_count", count, 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_instr", instr, 0);
      chk("rst_pc", instr_pc, 0);
      rst = 1'b0; instr_ready = 1'b1;
      @(negedge clk);
      chk("t1_req0", imem_req, 1);
      chk("t1_addr0", imem_addr, 0);
      chk("t1_valid0", instr_valid, 0);
      @(negedge clk);
      chk("t1_addr1", imem_addr, 4);
      chk("t1_valid1", instr_valid, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t1_valid", instr_valid, 1);
         chk("t1_pc", instr_pc, 32'(i * 4));
         chk("t1_count", count, 1);
      end
      @(posedge clk); #1 rst = 1'b1; instr_ready = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      repeat (8) @(negedge clk);
      chk("t2_full", count, 4);
      chk("t2_req", imem_req, 0);
      chk("t2_addr", imem_addr, 32'h10);
      @(posedge clk); #1 instr_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t2_valid", instr_valid, 1);
         chk("t2_pc", instr_pc, 32'(i * 4));
      end
      @(posedge clk); #1 redirect = 1'b1; redirect_pc = 32'h100;
      chk("t3_pre_count", count, 3);
      @(negedge clk);
      chk("t3_req_n", imem_req, 0);
      @(posedge clk); #1 redirect = 1'b0;
      @(negedge clk);
      chk("t3_valid1", instr_valid, 0);
      chk("t3_count1", count, 0);
      chk("t3_req1", imem_req, 1);
      chk("t3_addr1", imem_addr, 32'h100);
      @(negedge clk);
      chk("t3_valid2", instr_valid, 0);
      @(negedge clk);
      chk("t3_valid3", instr_valid, 1);
      chk("t3_pc3", instr_pc, 32'h100);
      @(posedge clk); #1 instr_ready = 1'b0;
      repeat (6) @(posedge clk);
      #1 instr_ready = 1'b1;
      chk("t4_full", count, 4);
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t4_count", count, 3);
         chk("t4_req", imem_req, 1);
         chk("t4_valid", instr_valid, 1);
      end
      @(posedge clk); #2 rst = 1'b1;
      #1;
      chk("t6_valid", instr_valid, 0);
      chk("t6_req", imem_req, 0);
      chk("t6_count", count, 0);
      chk("t6_addr", imem_addr, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("t6_req0", imem_req, 1);
      chk("t6_addr0", imem_addr, 0);
      @(negedge clk);
      @(negedge clk);
      chk("t6_valid2", instr_valid, 1);
      chk("t6_pc2", instr_pc, 0);
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         instr_ready = $urandom_range(0, 3) != 0;
         redirect = $urandom_range(0, 15) == 0;
         redirect_pc = $urandom;
      end
      @(posedge clk); #1 redirect = 1'b0; instr_ready = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("wrap_seen", w_pops >= 4, 1);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
